// File: rtl/pixel_fill_writer_if.sv
// Command / write-data port between the fill writer and the memory controller.
interface pixel_fill_writer_if;
    logic        mem_cmd_en;
    logic [2:0]  mem_cmd_instr;
    logic [5:0]  mem_cmd_bl;
    logic [29:0] mem_cmd_byte_addr;
    logic        mem_cmd_full;
    logic        mem_wr_en;
    logic [3:0]  mem_wr_mask;
    logic [31:0] mem_wr_data;
    logic        mem_wr_full;
    logic        mem_wr_empty;

    modport master (
        output mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
        output mem_wr_en, mem_wr_mask, mem_wr_data,
        input  mem_cmd_full, mem_wr_full, mem_wr_empty
    );

    modport slave (
        input  mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
        input  mem_wr_en, mem_wr_mask, mem_wr_data,
        output mem_cmd_full, mem_wr_full, mem_wr_empty
    );
endinterface

// File: rtl/pixel_fill_writer.sv
// Framebuffer writer: single pixels and rectangle fills, one burst command per row,
// with an optional full-screen clear after memory calibration.
module pixel_fill_writer #(
    parameter int                        X_BITS         = 8,
    parameter int                        Y_BITS         = 8,
    parameter int                        SCREEN_H       = 192,
    parameter logic [29-X_BITS-Y_BITS:0] GFX_PREFIX     = '0,
    parameter bit                        CLEAR_ON_START = 1'b1,
    parameter logic [7:0]                INIT_RGB       = 8'h00
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                calib_done,
    output logic                init_done,
    output logic                ready,
    output logic                done,
    input  logic                pixel_en,
    input  logic [X_BITS-1:0]   pixel_x,
    input  logic [Y_BITS-1:0]   pixel_y,
    input  logic [7:0]          pixel_rgb,
    input  logic                fill_en,
    input  logic [X_BITS-1:0]   fill_x0,
    input  logic [X_BITS-1:0]   fill_x1,
    input  logic [Y_BITS-1:0]   fill_y0,
    input  logic [Y_BITS-1:0]   fill_y1,
    input  logic [7:0]          fill_rgb,
    pixel_fill_writer_if.master mem
);
    localparam int W_BITS = X_BITS - 2;

    typedef enum logic [2:0] {
        INIT, IDLE, ROW_WRITE, ROW_CMD, ROW_WAIT, PIX_CMD
    } state_t;

    state_t state, state_nxt;
    logic   init_mode;

    logic [W_BITS-1:0] cur_w, w0, w1, row_bl;
    logic [1:0]        x0_lo, x1_lo;
    logic [Y_BITS-1:0] row_y, y1;
    logic [7:0]        rgb;
    logic [29:0]       cmd_addr;

    logic accept_pix, accept_fill, fill_bad, load_init, set_init_done;
    logic word_step, row_adv, op_end;

    // Bytes left of x0 in the first word and right of x1 in the last word are masked.
    function automatic logic [3:0] edge_mask(input logic first, input logic last,
                                             input logic [1:0] lo, input logic [1:0] hi);
        logic [3:0] m;
        m = 4'b0000;
        for (int b = 0; b < 4; b++)
            m[b] = (first && (2'(b) < lo)) || (last && (2'(b) > hi));
        return m;
    endfunction

    assign row_bl   = w1 - w0;
    assign cmd_addr = {GFX_PREFIX, row_y, w0, 2'b00};

    always_comb begin
        state_nxt             = state;
        ready                 = 1'b0;
        accept_pix            = 1'b0;
        accept_fill           = 1'b0;
        fill_bad              = 1'b0;
        load_init             = 1'b0;
        set_init_done         = 1'b0;
        word_step             = 1'b0;
        row_adv               = 1'b0;
        op_end                = 1'b0;
        mem.mem_cmd_en        = 1'b0;
        mem.mem_cmd_instr     = 3'b000;
        mem.mem_cmd_bl        = 6'd0;
        mem.mem_cmd_byte_addr = {GFX_PREFIX, {(X_BITS + Y_BITS){1'b0}}};
        mem.mem_wr_en         = 1'b0;
        mem.mem_wr_mask       = 4'b1111;
        mem.mem_wr_data       = 32'd0;

        // Everything is frozen until the memory is calibrated, and silenced during reset.
        if (calib_done && !rst) begin
            case (state)
                INIT: begin
                    if (CLEAR_ON_START) begin
                        load_init = 1'b1;
                        state_nxt = ROW_WRITE;
                    end else begin
                        set_init_done = 1'b1;
                        state_nxt     = IDLE;
                    end
                end
                IDLE: begin
                    ready = !mem.mem_cmd_full && !mem.mem_wr_full;
                    if (ready && pixel_en) begin
                        accept_pix      = 1'b1;
                        mem.mem_wr_en   = 1'b1;
                        mem.mem_wr_data = {4{pixel_rgb}};
                        mem.mem_wr_mask = ~(4'b0001 << pixel_x[1:0]);
                        state_nxt       = PIX_CMD;
                    end else if (ready && fill_en) begin
                        accept_fill = 1'b1;
                        if ((fill_x0 > fill_x1) || (fill_y0 > fill_y1))
                            fill_bad = 1'b1;
                        else
                            state_nxt = ROW_WRITE;
                    end
                end
                ROW_WRITE: begin
                    if (!mem.mem_wr_full) begin
                        mem.mem_wr_en   = 1'b1;
                        mem.mem_wr_data = {4{rgb}};
                        mem.mem_wr_mask = edge_mask(cur_w == w0, cur_w == w1, x0_lo, x1_lo);
                        if (cur_w == w1)
                            state_nxt = ROW_CMD;
                        else
                            word_step = 1'b1;
                    end
                end
                ROW_CMD: begin
                    if (!mem.mem_cmd_full) begin
                        mem.mem_cmd_en        = 1'b1;
                        mem.mem_cmd_bl        = 6'(row_bl);
                        mem.mem_cmd_byte_addr = cmd_addr;
                        state_nxt             = ROW_WAIT;
                    end
                end
                ROW_WAIT: begin
                    // Compare before incrementing so the last row never wraps the counter.
                    if (mem.mem_wr_empty) begin
                        if (row_y == y1) begin
                            op_end    = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            row_adv   = 1'b1;
                            state_nxt = ROW_WRITE;
                        end
                    end
                end
                PIX_CMD: begin
                    if (!mem.mem_cmd_full) begin
                        mem.mem_cmd_en        = 1'b1;
                        mem.mem_cmd_byte_addr = cmd_addr;
                        op_end                = 1'b1;
                        state_nxt             = IDLE;
                    end
                end
                default: state_nxt = INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            init_mode <= 1'b0;
            done      <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= fill_bad || (op_end && !init_mode);
            if (set_init_done || (op_end && init_mode))
                init_done <= 1'b1;
            if (load_init)
                init_mode <= 1'b1;
            else if (accept_fill || op_end)
                init_mode <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load_init) begin
            w0    <= '0;
            cur_w <= '0;
            w1    <= '1;
            x0_lo <= 2'b00;
            x1_lo <= 2'b11;
            row_y <= '0;
            y1    <= Y_BITS'(SCREEN_H - 1);
            rgb   <= INIT_RGB;
        end else if (accept_pix) begin
            w0    <= pixel_x[X_BITS-1:2];
            row_y <= pixel_y;
        end else if (accept_fill) begin
            w0    <= fill_x0[X_BITS-1:2];
            cur_w <= fill_x0[X_BITS-1:2];
            w1    <= fill_x1[X_BITS-1:2];
            x0_lo <= fill_x0[1:0];
            x1_lo <= fill_x1[1:0];
            row_y <= fill_y0;
            y1    <= fill_y1;
            rgb   <= fill_rgb;
        end else if (word_step) begin
            cur_w <= cur_w + W_BITS'(1);
        end else if (row_adv) begin
            row_y <= row_y + Y_BITS'(1);
            cur_w <= w0;
        end
    end
endmodule

// File: tb/tb_pixel_fill_writer.sv
// Bench for pixel_fill_writer: memory-side model with random drain, traffic scoreboard.
module tb_pixel_fill_writer;
    logic       clk = 1'b0;
    logic       rst, calib_done, init_done, ready, done;
    logic       pixel_en, fill_en;
    logic [7:0] pixel_x, pixel_y, pixel_rgb;
    logic [7:0] fill_x0, fill_x1, fill_y0, fill_y1, fill_rgb;

    pixel_fill_writer_if mem();

    pixel_fill_writer dut (
        .clk(clk), .rst(rst), .calib_done(calib_done), .init_done(init_done),
        .ready(ready), .done(done),
        .pixel_en(pixel_en), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_rgb(pixel_rgb),
        .fill_en(fill_en), .fill_x0(fill_x0), .fill_x1(fill_x1),
        .fill_y0(fill_y0), .fill_y1(fill_y1), .fill_rgb(fill_rgb),
        .mem(mem)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] wq_data[$];
    logic [3:0]  wq_mask[$];
    logic [5:0]  cq_bl[$];
    logic [29:0] cq_addr[$];
    logic [31:0] ex_data[$];
    logic [3:0]  ex_mask[$];
    logic [5:0]  ex_bl[$];
    logic [29:0] ex_addr[$];
    int done_cnt = 0, viol_cnt = 0, fifo_cnt = 0;
    bit bp_mode = 1'b0, cmd_bp = 1'b0;

    // Memory side: record traffic at negedge, update FIFO flags just after posedge.
    initial begin : mon
        bit push;
        mem.mem_cmd_full = 1'b0;
        mem.mem_wr_full  = 1'b0;
        mem.mem_wr_empty = 1'b1;
        forever begin
            @(negedge clk);
            push = mem.mem_wr_en;
            if (mem.mem_wr_en) begin
                wq_data.push_back(mem.mem_wr_data);
                wq_mask.push_back(mem.mem_wr_mask);
                if (mem.mem_wr_full) viol_cnt++;
            end
            if (mem.mem_cmd_en) begin
                cq_bl.push_back(mem.mem_cmd_bl);
                cq_addr.push_back(mem.mem_cmd_byte_addr);
                if (mem.mem_cmd_full || mem.mem_cmd_instr != 3'b000) viol_cnt++;
            end
            if (done) done_cnt++;
            @(posedge clk);
            #1;
            if (push) fifo_cnt++;
            if (fifo_cnt > 0 && $urandom_range(0, 3) != 0) fifo_cnt--;
            mem.mem_wr_empty = (fifo_cnt == 0);
            mem.mem_wr_full  = bp_mode ? ~mem.mem_wr_full : 1'b0;
            mem.mem_cmd_full = cmd_bp ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
    end

    task automatic clear_q();
        wq_data.delete(); wq_mask.delete(); cq_bl.delete(); cq_addr.delete();
        ex_data.delete(); ex_mask.delete(); ex_bl.delete(); ex_addr.delete();
        done_cnt = 0;
        viol_cnt = 0;
    endtask

    // Reference: each row y gets words x0/4..x1/4; a byte is masked iff its pixel lies outside [x0,x1].
    task automatic model_fill(input int x0, input int x1, input int y0, input int y1, input logic [7:0] c);
        for (int y = y0; y <= y1; y++) begin
            for (int w = x0 / 4; w <= x1 / 4; w++) begin
                logic [3:0] m;
                m = 4'b0000;
                for (int b = 0; b < 4; b++)
                    if (w * 4 + b < x0 || w * 4 + b > x1) m[b] = 1'b1;
                ex_data.push_back({4{c}});
                ex_mask.push_back(m);
            end
            ex_bl.push_back(6'(x1 / 4 - x0 / 4));
            ex_addr.push_back(30'(y * 256 + (x0 / 4) * 4));
        end
    endtask

    task automatic model_pixel(input int x, input int y, input logic [7:0] c);
        logic [3:0] m;
        for (int b = 0; b < 4; b++) m[b] = (b != x % 4);
        ex_data.push_back({4{c}});
        ex_mask.push_back(m);
        ex_bl.push_back(6'd0);
        ex_addr.push_back(30'(y * 256 + (x / 4) * 4));
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (ready) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (done) begin lat = n; break; end
        end
    endtask

    task automatic issue_pixel(input int x, input int y, input logic [7:0] c, output int lat);
        bit ok;
        @(posedge clk); #1;
        pixel_x = 8'(x); pixel_y = 8'(y); pixel_rgb = c; pixel_en = 1'b1;
        wait_ready(ok);
        @(posedge clk); #1;
        pixel_en = 1'b0;
        lat = -1;
        if (ok) wait_done(50, lat);
    endtask

    task automatic issue_fill(input int x0, input int x1, input int y0, input int y1,
                              input logic [7:0] c, output int lat);
        bit ok;
        @(posedge clk); #1;
        fill_x0 = 8'(x0); fill_x1 = 8'(x1); fill_y0 = 8'(y0); fill_y1 = 8'(y1);
        fill_rgb = c; fill_en = 1'b1;
        wait_ready(ok);
        @(posedge clk); #1;
        fill_en = 1'b0;
        lat = -1;
        if (ok) wait_done(30000, lat);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_tests++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (mem.mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", mem.mem_wr_en); end
        n_tests++; if (mem.mem_cmd_en !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_en: got %b want 0", mem.mem_cmd_en); end
        n_tests++; if (mem.mem_wr_mask !== 4'b1111) begin n_fail++; $display("FAIL reset_mask: got %b want 1111", mem.mem_wr_mask); end
        n_tests++; if (mem.mem_wr_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", mem.mem_wr_data); end
        n_tests++; if (mem.mem_cmd_bl !== 6'd0) begin n_fail++; $display("FAIL reset_bl: got %0d want 0", mem.mem_cmd_bl); end
        n_tests++; if (mem.mem_cmd_byte_addr !== 30'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mem.mem_cmd_byte_addr); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        n_tests++; if (wq_data.size() + cq_bl.size() != 0) begin n_fail++; $display("FAIL calib_hold_traffic: got %0d pushes want 0", wq_data.size() + cq_bl.size()); end
        n_tests++; if (init_done !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL calib_hold_flags: got init_done=%b ready=%b want 0/0", init_done, ready); end
    endtask

    task automatic test_startup();
        int bad;
        bit ok;
        clear_q();
        calib_done = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60000; i++) begin
            @(negedge clk);
            if (init_done) begin ok = 1'b1; break; end
        end
        repeat (3) @(negedge clk);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL startup_init_done: got 0 want 1 within budget"); end
        n_tests++; if (cq_bl.size() != 192) begin n_fail++; $display("FAIL startup_cmd_count: got %0d want 192", cq_bl.size()); end
        bad = 0;
        for (int i = 0; i < cq_bl.size(); i++)
            if (cq_bl[i] !== 6'd63 || cq_addr[i] !== 30'(i * 256)) bad++;
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL startup_cmds: got %0d wrong commands want 0", bad); end
        n_tests++; if (wq_data.size() != 12288) begin n_fail++; $display("FAIL startup_word_count: got %0d want 12288", wq_data.size()); end
        bad = 0;
        for (int i = 0; i < wq_data.size(); i++)
            if (wq_data[i] !== 32'd0 || wq_mask[i] !== 4'b0000) bad++;
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL startup_words: got %0d wrong words want 0", bad); end
        n_tests++; if (done_cnt != 0) begin n_fail++; $display("FAIL startup_done: got %0d pulses want 0", done_cnt); end
        n_tests++; if (viol_cnt != 0) begin n_fail++; $display("FAIL startup_protocol: got %0d violations want 0", viol_cnt); end
    endtask

    task automatic test_pixel();
        int lat, n, x, y;
        logic [7:0] c;
        clear_q();
        issue_pixel(8'h13, 8'h05, 8'hA5, lat);
        model_pixel(8'h13, 8'h05, 8'hA5);
        n_tests++; if (lat != 2) begin n_fail++; $display("FAIL pixel_latency: got %0d want 2", lat); end
        for (int k = 0; k < 6; k++) begin
            x = $urandom_range(0, 255); y = $urandom_range(0, 255); c = 8'($urandom);
            issue_pixel(x, y, c, lat);
            model_pixel(x, y, c);
            n_tests++; if (lat != 2) begin n_fail++; $display("FAIL pixel_rand_latency: got %0d want 2", lat); end
        end
        repeat (3) @(negedge clk);
        n_tests++; if (wq_data.size() != ex_data.size()) begin n_fail++; $display("FAIL pixel_word_count: got %0d want %0d", wq_data.size(), ex_data.size()); end
        n_tests++; if (cq_bl.size() != ex_bl.size()) begin n_fail++; $display("FAIL pixel_cmd_count: got %0d want %0d", cq_bl.size(), ex_bl.size()); end
        n = (wq_data.size() < ex_data.size()) ? wq_data.size() : ex_data.size();
        for (int i = 0; i < n; i++) begin
            n_tests++;
            if (wq_data[i] !== ex_data[i] || wq_mask[i] !== ex_mask[i]) begin
                n_fail++; $display("FAIL pixel_word[%0d]: got %h/%b want %h/%b", i, wq_data[i], wq_mask[i], ex_data[i], ex_mask[i]);
            end
        end
        n = (cq_bl.size() < ex_bl.size()) ? cq_bl.size() : ex_bl.size();
        for (int i = 0; i < n; i++) begin
            n_tests++;
            if (cq_bl[i] !== ex_bl[i] || cq_addr[i] !== ex_addr[i]) begin
                n_fail++; $display("FAIL pixel_cmd[%0d]: got bl=%0d addr=%h want bl=%0d addr=%h", i, cq_bl[i], cq_addr[i], ex_bl[i], ex_addr[i]);
            end
        end
        n_tests++; if (done_cnt != 7) begin n_fail++; $display("FAIL pixel_done_count: got %0d want 7", done_cnt); end
    endtask

    task automatic test_fill();
        int lat, n, x0, x1, y0, y1;
        logic [7:0] c;
        clear_q();
        issue_fill(2, 9, 3, 3, 8'h3C, lat);
        model_fill(2, 9, 3, 3, 8'h3C);
        n_tests++; if (lat < 0) begin n_fail++; $display("FAIL fill_directed_done: got timeout want pulse"); end
        issue_fill(250, 255, 254, 255, 8'hE1, lat);
        model_fill(250, 255, 254, 255, 8'hE1);
        n_tests++; if (lat < 0) begin n_fail++; $display("FAIL fill_corner_done: got timeout want pulse"); end
        cmd_bp = 1'b1;
        for (int k = 0; k < 6; k++) begin
            x0 = $urandom_range(0, 255);
            x1 = x0 + $urandom_range(0, 40); if (x1 > 255) x1 = 255;
            y0 = $urandom_range(0, 255);
            y1 = y0 + $urandom_range(0, 2); if (y1 > 255) y1 = 255;
            c = 8'($urandom);
            issue_fill(x0, x1, y0, y1, c, lat);
            model_fill(x0, x1, y0, y1, c);
            n_tests++; if (lat < 0) begin n_fail++; $display("FAIL fill_rand_done: got timeout want pulse"); end
        end
        cmd_bp = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (wq_data.size() != ex_data.size()) begin n_fail++; $display("FAIL fill_word_count: got %0d want %0d", wq_data.size(), ex_data.size()); end
        n_tests++; if (cq_bl.size() != ex_bl.size()) begin n_fail++; $display("FAIL fill_cmd_count: got %0d want %0d", cq_bl.size(), ex_bl.size()); end
        n = (wq_data.size() < ex_data.size()) ? wq_data.size() : ex_data.size();
        for (int i = 0; i < n; i++) begin
            n_tests++;
            if (wq_data[i] !== ex_data[i] || wq_mask[i] !== ex_mask[i]) begin
                n_fail++; $display("FAIL fill_word[%0d]: got %h/%b want %h/%b", i, wq_data[i], wq_mask[i], ex_data[i], ex_mask[i]);
            end
        end
        n = (cq_bl.size() < ex_bl.size()) ? cq_bl.size() : ex_bl.size();
        for (int i = 0; i < n; i++) begin
            n_tests++;
            if (cq_bl[i] !== ex_bl[i] || cq_addr[i] !== ex_addr[i]) begin
                n_fail++; $display("FAIL fill_cmd[%0d]: got bl=%0d addr=%h want bl=%0d addr=%h", i, cq_bl[i], cq_addr[i], ex_bl[i], ex_addr[i]);
            end
        end
        n_tests++; if (done_cnt != 8) begin n_fail++; $display("FAIL fill_done_count: got %0d want 8", done_cnt); end
        n_tests++; if (viol_cnt != 0) begin n_fail++; $display("FAIL fill_protocol: got %0d violations want 0", viol_cnt); end
    endtask

    task automatic test_backpressure();
        int lat;
        clear_q();
        bp_mode = 1'b1;
        issue_fill(0, 255, 7, 7, 8'h6B, lat);
        bp_mode = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (lat < 0) begin n_fail++; $display("FAIL bp_done: got timeout want pulse"); end
        n_tests++; if (wq_data.size() != 64) begin n_fail++; $display("FAIL bp_word_count: got %0d want 64", wq_data.size()); end
        n_tests++; if (viol_cnt != 0) begin n_fail++; $display("FAIL bp_push_while_full: got %0d want 0", viol_cnt); end
        n_tests++; if (cq_bl.size() != 1) begin n_fail++; $display("FAIL bp_cmd_count: got %0d want 1", cq_bl.size()); end
        if (cq_bl.size() == 1) begin
            n_tests++;
            if (cq_bl[0] !== 6'd63 || cq_addr[0] !== 30'h700) begin
                n_fail++; $display("FAIL bp_cmd: got bl=%0d addr=%h want bl=63 addr=700", cq_bl[0], cq_addr[0]);
            end
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        int lat, n;
        clear_q();
        @(posedge clk); #1;
        pixel_x = 8'h21; pixel_y = 8'h40; pixel_rgb = 8'h5A; pixel_en = 1'b1;
        fill_x0 = 8'd4; fill_x1 = 8'd11; fill_y0 = 8'h41; fill_y1 = 8'h41; fill_rgb = 8'h77; fill_en = 1'b1;
        wait_ready(ok);
        @(posedge clk); #1;
        pixel_en = 1'b0;
        wait_ready(ok);
        @(posedge clk); #1;
        fill_en = 1'b0;
        wait_done(30000, lat);
        model_pixel(8'h21, 8'h40, 8'h5A);
        model_fill(4, 11, 8'h41, 8'h41, 8'h77);
        repeat (3) @(negedge clk);
        n_tests++; if (!ok || lat < 0) begin n_fail++; $display("FAIL simul_complete: got ok=%0d lat=%0d want ok=1 lat>=0", ok, lat); end
        n_tests++; if (done_cnt != 2) begin n_fail++; $display("FAIL simul_done_count: got %0d want 2", done_cnt); end
        n_tests++; if (wq_data.size() != ex_data.size() || cq_bl.size() != ex_bl.size()) begin
            n_fail++; $display("FAIL simul_counts: got %0d words %0d cmds want %0d/%0d", wq_data.size(), cq_bl.size(), ex_data.size(), ex_bl.size());
        end
        n = (wq_data.size() < ex_data.size()) ? wq_data.size() : ex_data.size();
        for (int i = 0; i < n; i++) begin
            n_tests++;
            if (wq_data[i] !== ex_data[i] || wq_mask[i] !== ex_mask[i]) begin
                n_fail++; $display("FAIL simul_word[%0d]: got %h/%b want %h/%b", i, wq_data[i], wq_mask[i], ex_data[i], ex_mask[i]);
            end
        end
        n = (cq_bl.size() < ex_bl.size()) ? cq_bl.size() : ex_bl.size();
        for (int i = 0; i < n; i++) begin
            n_tests++;
            if (cq_bl[i] !== ex_bl[i] || cq_addr[i] !== ex_addr[i]) begin
                n_fail++; $display("FAIL simul_cmd[%0d]: got bl=%0d addr=%h want bl=%0d addr=%h", i, cq_bl[i], cq_addr[i], ex_bl[i], ex_addr[i]);
            end
        end
        clear_q();
        issue_fill(9, 2, 3, 3, 8'h11, lat);
        n_tests++; if (lat != 1) begin n_fail++; $display("FAIL degen_x_latency: got %0d want 1", lat); end
        issue_fill(0, 3, 9, 4, 8'h22, lat);
        n_tests++; if (lat != 1) begin n_fail++; $display("FAIL degen_y_latency: got %0d want 1", lat); end
        repeat (5) @(negedge clk);
        n_tests++; if (wq_data.size() + cq_bl.size() != 0) begin n_fail++; $display("FAIL degen_traffic: got %0d pushes want 0", wq_data.size() + cq_bl.size()); end
        n_tests++; if (done_cnt != 2) begin n_fail++; $display("FAIL degen_done_count: got %0d want 2", done_cnt); end
    endtask

    task automatic test_reset_mid_fill();
        bit ok;
        int ncmd;
        clear_q();
        @(posedge clk); #1;
        fill_x0 = 8'd0; fill_x1 = 8'd255; fill_y0 = 8'd10; fill_y1 = 8'd20; fill_rgb = 8'hC3; fill_en = 1'b1;
        wait_ready(ok);
        @(posedge clk); #1;
        fill_en = 1'b0;
        for (int i = 0; i < 5000 && wq_data.size() < 100; i++) @(negedge clk);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem.mem_wr_en) begin ok = 1'b1; break; end
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL midreset_reach_row_write: got timeout want write burst"); end
        @(posedge clk); #1;
        rst = 1'b1;
        ncmd = cq_bl.size();
        @(negedge clk);
        n_tests++; if (mem.mem_wr_en !== 1'b0 || mem.mem_cmd_en !== 1'b0 || ready !== 1'b0) begin
            n_fail++; $display("FAIL midreset_silent: got wr_en=%b cmd_en=%b ready=%b want 0/0/0", mem.mem_wr_en, mem.mem_cmd_en, ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        calib_done = 1'b0;
        @(negedge clk);
        n_tests++; if (init_done !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: got init_done=%b done=%b want 0/0", init_done, done); end
        n_tests++; if (mem.mem_wr_mask !== 4'b1111 || mem.mem_wr_data !== 32'd0) begin
            n_fail++; $display("FAIL midreset_wr_bus: got mask=%b data=%h want 1111/0", mem.mem_wr_mask, mem.mem_wr_data);
        end
        n_tests++; if (mem.mem_cmd_bl !== 6'd0 || mem.mem_cmd_byte_addr !== 30'd0) begin
            n_fail++; $display("FAIL midreset_cmd_bus: got bl=%0d addr=%h want 0/0", mem.mem_cmd_bl, mem.mem_cmd_byte_addr);
        end
        repeat (10) @(negedge clk);
        n_tests++; if (cq_bl.size() != ncmd) begin n_fail++; $display("FAIL midreset_partial_cmd: got %0d cmds want %0d", cq_bl.size(), ncmd); end
        clear_q();
        calib_done = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60000; i++) begin
            @(negedge clk);
            if (init_done) begin ok = 1'b1; break; end
        end
        repeat (3) @(negedge clk);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL midreset_reinit: got no init_done want 1"); end
        n_tests++; if (cq_bl.size() != 192 || wq_data.size() != 12288) begin
            n_fail++; $display("FAIL midreset_reclear: got %0d cmds %0d words want 192/12288", cq_bl.size(), wq_data.size());
        end
        if (cq_bl.size() > 0) begin
            n_tests++;
            if (cq_bl[0] !== 6'd63 || cq_addr[0] !== 30'd0) begin
                n_fail++; $display("FAIL midreset_first_cmd: got bl=%0d addr=%h want 63/0", cq_bl[0], cq_addr[0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; calib_done = 1'b0;
        pixel_en = 1'b0; pixel_x = '0; pixel_y = '0; pixel_rgb = '0;
        fill_en = 1'b0; fill_x0 = '0; fill_x1 = '0; fill_y0 = '0; fill_y1 = '0; fill_rgb = '0;
        test_reset();
        test_startup();
        test_pixel();
        test_fill();
        test_backpressure();
        test_simultaneous();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pixel_fill_writer.md
PIXEL_FILL_WRITER -- requirements
Module: pixel_fill_writer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- X_BITS, 8: pixel x width; SHALL be ≤ 8 so one row is ≤ 64 words.
- Y_BITS, 8: pixel y width.
- SCREEN_H, 192: rows cleared at start-up.
- GFX_PREFIX, 14'h0000: upper address bits; width is 30-X_BITS-Y_BITS.
- CLEAR_ON_START, 1: perform a start-up full-screen fill.
- INIT_RGB, 8'h00: start-up fill colour.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: the only clock.
- rst, in, 1: synchronous, active-high reset.
- calib_done, in, 1: memory ready; FSM holds while low.
- init_done, out, 1: start-up clear finished; sticky.
- ready, out, 1: a request may be accepted this cycle.
- done, out, 1: one-cycle pulse when a request completes.
- pixel_en, in, 1: single-pixel write request.
- pixel_x, in, X_BITS: pixel x coordinate.
- pixel_y, in, Y_BITS: pixel y coordinate.
- pixel_rgb, in, 8: pixel colour.
- fill_en, in, 1: rectangle fill request.
- fill_x0, in, X_BITS: inclusive left bound.
- fill_x1, in, X_BITS: inclusive right bound.
- fill_y0, in, Y_BITS: inclusive top bound.
- fill_y1, in, Y_BITS: inclusive bottom bound.
- fill_rgb, in, 8: fill colour.
- mem_cmd_en, out, 1: command FIFO push.
- mem_cmd_instr, out, 3: command; constant 3'b000 (write).
- mem_cmd_bl, out, 6: burst length minus one.
- mem_cmd_byte_addr, out, 30: command byte address.
- mem_cmd_full, in, 1: command FIFO full.
- mem_wr_en, out, 1: write-data FIFO push.
- mem_wr_mask, out, 4: byte mask; 1 = byte not written.
- mem_wr_data, out, 32: write data.
- mem_wr_full, in, 1: write-data FIFO full.
- mem_wr_empty, in, 1: write-data FIFO empty.

Function
REQ-003 Address of word w in row y SHALL be {GFX_PREFIX, y, w[X_BITS-3:0], 2'b00}; pixel x maps to word x[X_BITS-1:2], byte x[1:0].
REQ-004 States SHALL be INIT, IDLE, ROW_WRITE, ROW_CMD, ROW_WAIT and PIX_CMD; no state changes and no outputs are asserted while calib_done=0.
REQ-005 INIT: if CLEAR_ON_START=1, SHALL load the rectangle (0, 2^X_BITS-1, 0, SCREEN_H-1) with colour INIT_RGB and go to ROW_WRITE; otherwise SHALL go to IDLE and set init_done.
REQ-006 ready SHALL equal (state==IDLE && !mem_cmd_full && !mem_wr_full).
REQ-007 In IDLE with ready=1, pixel_en SHALL take priority over fill_en; fill_en is not latched while pixel_en is served, so the requester holds fill_en until accepted.
REQ-008 Pixel acceptance SHALL push one word with data {4{pixel_rgb}}, all mask bits 1 except bit pixel_x[1:0], and latch the address; next cycle PIX_CMD SHALL push the command with bl=0, pulse done and return to IDLE (2-cycle latency).
REQ-009 Fill acceptance SHALL latch all fill inputs; if x0>x1 or y0>y1, SHALL pulse done next cycle with no memory traffic and stay in IDLE.
REQ-010 ROW_WRITE SHALL push words w0=x0>>2 through w1=x1>>2, one per cycle, only in cycles with mem_wr_full=0, each with data {4{rgb}}.
REQ-011 Edge masks: in word w0, bytes below x0[1:0] SHALL be masked; in word w1, bytes above x1[1:0] SHALL be masked; when w0==w1 both rules apply; interior words SHALL use mask 0000.
REQ-012 ROW_CMD SHALL push one command with bl=w1-w0 at the row address of w0, waiting while mem_cmd_full=1.
REQ-013 ROW_WAIT SHALL hold until mem_wr_empty=1, then:
- if the current row is y1: pulse done (or set init_done for the start-up fill) and go to IDLE;
- otherwise: increment y and go to ROW_WRITE.
REQ-014 Counters SHALL NOT wrap: row 2^Y_BITS-1 and x1=2^X_BITS-1 SHALL terminate correctly.
REQ-015 mem_cmd_en and mem_wr_en SHALL each be high for at most one cycle per push.

Reset
REQ-016 rst SHALL force state INIT and clear mem_cmd_en, mem_wr_en, done, ready and init_done, with mem_wr_mask=4'b1111, mem_wr_data=0, mem_cmd_bl=0 and mem_cmd_byte_addr={GFX_PREFIX,0}.
REQ-017 Reset mid-fill SHALL abandon the operation without issuing a command for the partial row, then re-run INIT.

Verification
REQ-018 Start-up: CLEAR_ON_START=1, SCREEN_H=192, calib_done=1 -> 192 commands, each bl=63, addresses {P,y,8'h00} for y=0..191; 12288 data words of 0 with mask 0000; then init_done=1.
REQ-019 Pixel: pixel_x=0x13, pixel_y=0x05, rgb=0xA5 -> one word 0xA5A5A5A5 with mask 0111, command bl=0 at addr {P,0x05,0x10}, done 2 cycles after acceptance.
REQ-020 Fill: x0=2, x1=9, y0=y1=3, rgb=0x3C -> 3 words with masks 0011, 0000, 1100; command bl=2 at addr {P,0x03,0x00}; one done pulse.
REQ-021 Backpressure: mem_wr_full toggling every other cycle during a 64-word row -> exactly 64 pushes, none while full, one command.
REQ-022 Simultaneous requests and degenerate fill: pixel_en and fill_en in the same cycle -> pixel served first, fill accepted on a later ready cycle; fill with x0=9, x1=2 -> done pulse with no memory traffic.
REQ-023 Reset mid-fill: rst asserted during ROW_WRITE -> no further command, all outputs at their REQ-016 values, then the start-up clear restarts.
